// File: rtl/config_adder.sv
// Configurable-precision signed adder: one P-bit add or two independent P/2-bit
// lane adds, selected per operation, with a single registered output stage.
module config_adder #(
  parameter int P = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [P-1:0] a,
  input  logic signed [P-1:0] b,
  input  logic                halvedPrecision,
  input  logic                in_valid,
  output logic signed [P+1:0] sum,
  output logic                out_valid
);

  localparam int H = P / 2;

  // Full-width add: two guard bits so the result is always exact.
  function automatic logic signed [P+1:0] full_add(input logic signed [P-1:0] x,
                                                   input logic signed [P-1:0] y);
    logic signed [P+1:0] xe, ye;
    xe = {{2{x[P-1]}}, x};
    ye = {{2{y[P-1]}}, y};
    return xe + ye;
  endfunction

  function automatic logic signed [H:0] lane_add(input logic signed [H-1:0] x,
                                                 input logic signed [H-1:0] y);
    logic signed [H:0] xe, ye;
    xe = {x[H-1], x};
    ye = {y[H-1], y};
    return xe + ye;
  endfunction

  logic signed [P+1:0] sum_p0;
  logic signed [P+1:0] sum_p1;
  logic                vld_p1;

  // Stage 0: combinational add; lanes never share a carry in halved mode.
  always_comb begin
    sum_p0 = full_add(a, b);
    if (halvedPrecision)
      sum_p0 = {lane_add(a[P-1:H], b[P-1:H]), lane_add(a[H-1:0], b[H-1:0])};
  end

  // Stage 1: output register; sum holds through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid)
        sum_p1 <= sum_p0;
    end
  end

  assign sum       = sum_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_config_adder.sv
// Directed and random bench for config_adder at P=8 (10-bit result).
module tb_config_adder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] a, b;
  logic              halvedPrecision;
  logic              in_valid;
  logic signed [9:0] sum;
  logic              out_valid;

  int passed = 0;
  int total  = 0;

  config_adder #(.P(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .halvedPrecision(halvedPrecision), .in_valid(in_valid),
    .sum(sum), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Apply one set of inputs across a rising edge, then settle before sampling.
  task automatic drive(input logic v, input logic h, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v; halvedPrecision = h; a = av; b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'd5, 8'd5);
      total++;
      if (sum !== 10'sd0 || out_valid !== 1'b0)
        $display("FAIL reset[%0d]: sum=%0d out_valid=%b, required sum=0 out_valid=0", i, sum, out_valid);
      else passed++;
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'd5, 8'd5);
    total++;
    if (sum !== 10'sd10 || out_valid !== 1'b1)
      $display("FAIL reset_release: sum=%0d out_valid=%b, required sum=10 out_valid=1", sum, out_valid);
    else passed++;
  endtask

  task automatic test_full_directed();
    int ta[7] = '{0, 1, 8, 124, 124, -127, -127};
    int tb[7] = '{0, 2, -8, 3, 4, -1, -100};
    int te[7] = '{0, 3, 0, 127, 128, -128, -227};
    logic [7:0] av, bv;
    logic signed [9:0] e;
    for (int i = 0; i < 7; i++) begin
      av = ta[i][7:0]; bv = tb[i][7:0]; e = te[i][9:0];
      drive(1'b1, 1'b0, av, bv);
      total++;
      if (sum !== e || out_valid !== 1'b1)
        $display("FAIL full_dir[%0d] (%0d+%0d): sum=%0d vld=%b, required %0d vld=1",
                 i, ta[i], tb[i], sum, out_valid, te[i]);
      else passed++;
    end
  endtask

  task automatic test_full_random();
    int errs = 0;
    int ai, bi, s;
    logic [7:0] av, bv;
    logic signed [9:0] e;
    for (int i = 0; i < 100; i++) begin
      av = 8'($urandom); bv = 8'($urandom);
      ai = int'($signed(av)); bi = int'($signed(bv));
      s = ai + bi; e = s[9:0];
      drive(1'b1, 1'b0, av, bv);
      total++;
      if (sum !== e || out_valid !== 1'b1) begin
        errs++;
        if (errs < 5)
          $display("FAIL full_rand (%0d+%0d): sum=%0d vld=%b, required %0d vld=1", ai, bi, sum, out_valid, s);
      end else passed++;
    end
  endtask

  task automatic test_halved_isolation();
    drive(1'b1, 1'b1, 8'h77, 8'h77);
    total++;
    if (sum !== 10'h1CE || out_valid !== 1'b1)
      $display("FAIL halved_77: sum=%h vld=%b, required 1ce vld=1", sum, out_valid);
    else passed++;
    drive(1'b1, 1'b1, 8'h88, 8'h8F);
    total++;
    if (sum !== 10'h217 || out_valid !== 1'b1)
      $display("FAIL halved_neg: sum=%h vld=%b, required 217 (upper -16, lower -9)", sum, out_valid);
    else passed++;
  endtask

  task automatic test_halved_random();
    int errs = 0;
    int hi, lo;
    logic [3:0] ah, al, bh, bl;
    logic [9:0] e;
    for (int i = 0; i < 100; i++) begin
      ah = 4'($urandom); al = 4'($urandom); bh = 4'($urandom); bl = 4'($urandom);
      hi = int'($signed(ah)) + int'($signed(bh));
      lo = int'($signed(al)) + int'($signed(bl));
      e = {hi[4:0], lo[4:0]};
      drive(1'b1, 1'b1, {ah, al}, {bh, bl});
      total++;
      if (sum !== e || out_valid !== 1'b1) begin
        errs++;
        if (errs < 5)
          $display("FAIL halved_rand hi=%0d lo=%0d: sum=%h, required %h", hi, lo, sum, e);
      end else passed++;
    end
  endtask

  task automatic test_mode_toggle();
    // 7F+01: full gives 128; halved gives upper 7+0=7, lower -1+1=0.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i[0], 8'h7F, 8'h01);
      total++;
      if (i[0] ? (sum !== 10'h0E0) : (sum !== 10'sd128))
        $display("FAIL toggle[%0d] mode=%0d: sum=%h, required %h", i, i[0], sum, i[0] ? 10'h0E0 : 10'h080);
      else passed++;
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 1'b0, 8'd20, 8'd22);
    drive(1'b0, 1'b0, 8'd99, 8'd1);
    total++;
    if (out_valid !== 1'b0 || sum !== 10'sd42)
      $display("FAIL bubble: sum=%0d vld=%b, required sum=42 vld=0", sum, out_valid);
    else passed++;
    drive(1'b0, 1'b1, 8'h11, 8'h22);
    total++;
    if (out_valid !== 1'b0 || sum !== 10'sd42)
      $display("FAIL bubble2: sum=%0d vld=%b, required sum=42 vld=0", sum, out_valid);
    else passed++;
    drive(1'b1, 1'b0, 8'hF0, 8'hF0);
    total++;
    if (out_valid !== 1'b1 || sum !== -10'sd32)
      $display("FAIL after_bubble: sum=%0d vld=%b, required sum=-32 vld=1", sum, out_valid);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b0, 8'd50, 8'd60);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'd1, 8'd1);
    total++;
    if (sum !== 10'sd0 || out_valid !== 1'b0)
      $display("FAIL mid_reset: sum=%0d vld=%b, required sum=0 vld=0", sum, out_valid);
    else passed++;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'd3, 8'd4);
    total++;
    if (sum !== 10'sd7 || out_valid !== 1'b1)
      $display("FAIL mid_reset_release: sum=%0d vld=%b, required sum=7 vld=1", sum, out_valid);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; halvedPrecision = 1'b0; a = '0; b = '0;
    #2;
    test_reset();
    test_full_directed();
    test_full_random();
    test_halved_isolation();
    test_halved_random();
    test_mode_toggle();
    test_bubble();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
